// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: shared state encoding and counter phase lengths for the GEMM tile sequencer.
// LOAD_CYCLES/FEED_CYCLES are also used by the counter instance and the bench.
package gemm_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, WRITE, DONE} state_e;
  localparam int LOAD_CYCLES = 8;
  localparam int FEED_CYCLES = 14;
endpackage

// File: rtl/gemm_perf_cnt.sv
// gemm_perf_cnt: saturating up-counter with synchronous clear and enable.
// Ports: clk, rst_n (sync, active-low), i_clr (clear, wins over enable),
//        i_en (count enable), o_cnt (count, sticks at all-ones).
module gemm_perf_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + WIDTH'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl: sequences weight load, skewed activation feed and psum write-back
// for each tile of a GEMM job, driving the shared two-mode up-counter.
// Ports: start_i/num_tiles_i host request (sampled in IDLE only), stall_i pauses
//        LOAD_W/FEED, load_done_i/feed_done_i counter terminal flags,
//        cnt_en_o/cnt_sel_o counter control, w_load_o/a_feed_o/psum_we_o array strobes,
//        tile_idx_o tile index / psum address, busy_o/done_o job status,
//        perf_cyc_o busy cycles of the last or current job.
module gemm_tile_ctrl
  import gemm_ctrl_pkg::*;
#(
  parameter int TILE_WIDTH = 8,
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [TILE_WIDTH-1:0] num_tiles_i,
  input  logic                  stall_i,
  input  logic                  load_done_i,
  input  logic                  feed_done_i,
  output logic                  cnt_en_o,
  output logic                  cnt_sel_o,
  output logic                  w_load_o,
  output logic                  a_feed_o,
  output logic                  psum_we_o,
  output logic [TILE_WIDTH-1:0] tile_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [PERF_WIDTH-1:0] perf_cyc_o
);
  state_e                r_state, w_next;
  logic [TILE_WIDTH-1:0] r_ntiles, r_tile_idx;
  logic                  w_start, w_last;
  assign w_start = (r_state == IDLE) && start_i;
  assign w_last  = r_tile_idx == r_ntiles - TILE_WIDTH'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Done flags are only honoured in their own phase and never while stalled.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_i ? ((num_tiles_i != '0) ? LOAD_W : DONE) : IDLE;
      LOAD_W:  w_next = (!stall_i && load_done_i) ? FEED : LOAD_W;
      FEED:    w_next = (!stall_i && feed_done_i) ? WRITE : FEED;
      WRITE:   w_next = w_last ? DONE : LOAD_W;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // The tile index stops at ntiles-1 on the last tile, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ntiles   <= '0;
      r_tile_idx <= '0;
    end else begin
      if (w_start) r_ntiles <= num_tiles_i;
      if (r_state == WRITE && !w_last) r_tile_idx <= r_tile_idx + TILE_WIDTH'(1);
      else if (r_state == DONE) r_tile_idx <= '0;
    end
  end
  assign cnt_sel_o  = r_state == LOAD_W;
  assign w_load_o   = (r_state == LOAD_W) && !stall_i;
  assign a_feed_o   = (r_state == FEED) && !stall_i;
  assign cnt_en_o   = w_load_o || a_feed_o;
  assign psum_we_o  = r_state == WRITE;
  assign done_o     = r_state == DONE;
  assign busy_o     = r_state != IDLE;
  assign tile_idx_o = r_tile_idx;
  gemm_perf_cnt #(.WIDTH(PERF_WIDTH)) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_en  (r_state != IDLE),
    .o_cnt (perf_cyc_o)
  );
endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// tb_gemm_tile_ctrl: table-driven and randomized check of gemm_tile_ctrl against a phase-queue model.
module tb_gemm_tile_ctrl;
  import gemm_ctrl_pkg::*;
  localparam int TW = 8;
  localparam int PW = 12;
  localparam int PMAX = (1 << PW) - 1;
  logic clk = 0, rst_n = 0, start_i = 0, stall_i = 0, force_ff = 0;
  logic [TW-1:0] num_tiles_i = '0;
  logic load_done_i, feed_done_i;
  logic cnt_en_o, cnt_sel_o, w_load_o, a_feed_o, psum_we_o, busy_o, done_o;
  logic [TW-1:0] tile_idx_o;
  logic [PW-1:0] perf_cyc_o;
  int n_cmp = 0, n_bad = 0, cnt = 0;
  typedef struct {int kind; int rem; int tile;} ph_t;
  typedef struct {int n; int s1a; int s1l; int s2a; int s2l; int xs; int ff; int exp_done; int exp_perf;} vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  gemm_tile_ctrl #(.TILE_WIDTH(TW), .PERF_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_tiles_i(num_tiles_i), .stall_i(stall_i),
    .load_done_i(load_done_i), .feed_done_i(feed_done_i), .cnt_en_o(cnt_en_o), .cnt_sel_o(cnt_sel_o),
    .w_load_o(w_load_o), .a_feed_o(a_feed_o), .psum_we_o(psum_we_o), .tile_idx_o(tile_idx_o),
    .busy_o(busy_o), .done_o(done_o), .perf_cyc_o(perf_cyc_o)
  );
  // Stand-in for the shared two-mode counter: terminal flag on the last enabled cycle of the mode.
  always @(posedge clk) begin
    if (!rst_n) cnt <= 0;
    else if (cnt_en_o) cnt <= (cnt == (cnt_sel_o ? LOAD_CYCLES : FEED_CYCLES) - 1) ? 0 : cnt + 1;
  end
  assign load_done_i = cnt_en_o && cnt_sel_o && cnt == LOAD_CYCLES - 1;
  assign feed_done_i = (cnt_en_o && !cnt_sel_o && cnt == FEED_CYCLES - 1) || force_ff;
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h want %0h", nm, c, act, exp);
    end
  endtask
  function automatic logic [14:0] outs();
    return {cnt_en_o, cnt_sel_o, w_load_o, a_feed_o, psum_we_o, busy_o, done_o, tile_idx_o};
  endfunction
  // Job model: a queue of phases (0 load, 1 feed, 2 write, 3 done) with remaining work cycles.
  task automatic run_job(input int n, input int s1a, input int s1l, input int s2a, input int s2l,
                         input int xs, input int ff, input bit rnd, output int dcyc, output int busy);
    ph_t q[$];
    ph_t p;
    logic s;
    logic [14:0] e;
    dcyc = -1;
    busy = 0;
    for (int c = 0; c == 0 || q.size() > 0; c++) begin
      @(negedge clk);
      s = rnd ? ($urandom_range(0, 3) == 0) : ((c >= s1a && c < s1a + s1l) || (c >= s2a && c < s2a + s2l));
      stall_i = s;
      start_i = (c == 0) || (c == xs) || (rnd && c > 0 && $urandom_range(0, 7) == 0);
      num_tiles_i = (c == 0) ? TW'(n) : (c == xs) ? TW'(5) : TW'($urandom);
      force_ff = (c == ff);
      e = '0;
      if (c > 0) begin
        p = q[0];
        case (p.kind)
          0: e = {!s, 1'b1, !s, 1'b0, 1'b0, 1'b1, 1'b0, TW'(p.tile)};
          1: e = {!s, 1'b0, 1'b0, !s, 1'b0, 1'b1, 1'b0, TW'(p.tile)};
          2: e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, TW'(p.tile)};
          default: e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, TW'(p.tile)};
        endcase
      end
      #1;
      chk("outs", c, 32'(outs()), 32'(e));
      if (done_o && dcyc < 0) dcyc = c;
      if (c == 0) begin
        for (int t = 0; t < n; t++) begin
          q.push_back('{0, LOAD_CYCLES, t});
          q.push_back('{1, FEED_CYCLES, t});
          q.push_back('{2, 1, t});
        end
        q.push_back('{3, 1, (n == 0) ? 0 : n - 1});
      end else begin
        busy++;
        p = q.pop_front();
        if (!(p.kind < 2 && s)) p.rem--;
        if (p.rem > 0) q.push_front(p);
      end
    end
    @(negedge clk);
    start_i = 0;
    stall_i = 0;
    force_ff = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, b, n;
    tbl[0] = '{1, -1, 0, -1, 0, -1, -1, 24, 24};
    tbl[1] = '{3, -1, 0, -1, 0, -1, -1, 70, 70};
    tbl[2] = '{1, 3, 3, 15, 2, -1, -1, 29, 29};
    tbl[3] = '{0, -1, 0, -1, 0, -1, -1, 1, 1};
    tbl[4] = '{2, -1, 0, -1, 0, 12, 3, 47, 47};
    tbl[5] = '{255, -1, 0, -1, 0, -1, -1, 23 * 255 + 1, PMAX};
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_outs", 0, 32'(outs()), 32'd0);
    chk("reset_perf", 0, 32'(perf_cyc_o), 32'd0);
    foreach (tbl[i]) begin
      run_job(tbl[i].n, tbl[i].s1a, tbl[i].s1l, tbl[i].s2a, tbl[i].s2l, tbl[i].xs, tbl[i].ff, 1'b0, d, b);
      #1;
      chk($sformatf("tbl%0d_done_cyc", i), i, d, tbl[i].exp_done);
      chk($sformatf("tbl%0d_perf", i), i, 32'(perf_cyc_o), tbl[i].exp_perf);
      chk($sformatf("tbl%0d_idle", i), i, 32'({busy_o, tile_idx_o}), 32'd0);
    end
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 4);
      run_job(n, -1, 0, -1, 0, -1, -1, 1'b1, d, b);
      #1;
      chk("rnd_done_cyc", r, d, b);
      chk("rnd_perf", r, 32'(perf_cyc_o), (b > PMAX) ? PMAX : b);
    end
    // Reset during FEED cycle 5 of tile 1 of a 2-tile job, then a clean 1-tile job.
    @(negedge clk);
    start_i = 1;
    num_tiles_i = 2;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start_i = 0;
    end
    #1;
    chk("pre_rst_feed", 36, 32'({a_feed_o, tile_idx_o}), 32'({1'b1, 8'd1}));
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_outs", 0, 32'(outs()), 32'd0);
    chk("post_rst_perf", 0, 32'(perf_cyc_o), 32'd0);
    run_job(1, -1, 0, -1, 0, -1, -1, 1'b0, d, b);
    #1;
    chk("post_rst_done_cyc", 0, d, 24);
    chk("post_rst_perf_job", 0, 32'(perf_cyc_o), 32'd24);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
